// File: rtl/apb_subordinate_regs.sv
// apb_subordinate_regs
//
// APB completer for one selector line. Holds NumRegs word-aligned registers
// with byte-strobe writes and a fixed number of wait states per access.
// Read-only registers mirror hw_in; read-write registers are exported on
// reg_out. Unmapped, misaligned, read-only-write and unprivileged accesses
// complete with subError=1 and leave all registers untouched.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   reset     synchronous, active-high reset
//   sel       selector for this completer
//   enable    APB enable (access phase)
//   write     1 = write, 0 = read
//   addr      byte address relative to the completer base
//   wData     write data
//   strb      write byte strobes, one per data byte
//   prot      protection attributes; bit 0 = privileged
//   rData     read data, non-zero only on a completing, error-free read
//   ready     transfer completion
//   subError  error response, only asserted together with ready
//   hw_in     status values for read-only registers, register i = slice i
//   reg_out   read-write register contents, read-only slices drive 0
//
// FSM states
//   state  | meaning
//   IDLE   | no transfer in progress, waiting for a setup phase
//   ACCESS | access phase; wait counter runs down, ready=1 once it hits 0

module apb_subordinate_regs #(
    parameter int                  DataWidth  = 32,
    parameter int                  AddrWidth  = 32,
    parameter int                  ProtWidth  = 4,
    parameter int                  NumRegs    = 8,
    parameter int                  WaitStates = 1,
    parameter logic [NumRegs-1:0]  RoMask     = 8'b1100_0000,
    parameter logic [NumRegs-1:0]  PrivMask   = 8'b0000_0001
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sel,
    input  logic                         enable,
    input  logic                         write,
    input  logic [AddrWidth-1:0]         addr,
    input  logic [DataWidth-1:0]         wData,
    input  logic [DataWidth/8-1:0]       strb,
    input  logic [ProtWidth-1:0]         prot,
    output logic [DataWidth-1:0]         rData,
    output logic                         ready,
    output logic                         subError,
    input  logic [NumRegs*DataWidth-1:0] hw_in,
    output logic [NumRegs*DataWidth-1:0] reg_out
);

    localparam int IdxW     = $clog2(NumRegs);
    localparam int NumLanes = DataWidth / 8;
    // Keep the counter at least one bit wide so a zero-wait build still elaborates.
    localparam int CntW     = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WaitStates);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [DataWidth-1:0] regs_q [NumRegs];

    logic [IdxW-1:0]      idx;
    logic                 in_range;
    logic                 misaligned;
    logic                 err_cond;
    logic                 commit;
    logic [DataWidth-1:0] rd_word;

    // Only prot[0] carries meaning here; the remaining bits are accepted and ignored.
    logic unused_prot;
    assign unused_prot = ^prot[ProtWidth-1:1];

    // ------------------------------------------------------------------
    // Address decode and error detection
    // ------------------------------------------------------------------
    assign idx        = addr[IdxW+1:2];
    assign in_range   = (addr >> (IdxW + 2)) == '0;
    assign misaligned = addr[1:0] != 2'b00;

    // idx is only meaningful when in_range; the masks are still indexed with
    // it unconditionally, which is harmless because in_range gates the result.
    assign err_cond = !in_range
                    || misaligned
                    || (write && RoMask[idx])
                    || (PrivMask[idx] && !prot[0]);

    assign rd_word = RoMask[idx] ? hw_in[int'(idx)*DataWidth +: DataWidth]
                                 : regs_q[idx];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready    = 1'b0;
        subError = 1'b0;
        rData    = '0;
        commit   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // sel with enable already high is a protocol violation and is ignored.
                if (sel && !enable) begin
                    state_d = ACCESS;
                    cnt_d   = CntLoad;
                end
            end

            ACCESS: begin
                // ready depends only on registered state; the data-side outputs
                // are qualified by it.
                ready = (cnt_q == '0);
                if (ready) begin
                    subError = err_cond;
                    if (!write && !err_cond) begin
                        rData = rd_word;
                    end
                end

                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (enable) begin
                    state_d = IDLE;
                    commit  = write && !err_cond;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    // Read-only slots are never written (the error decode blocks them), so
    // their flops stay at reset value and fold away.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < NumLanes; b++) begin
                if (strb[b]) begin
                    regs_q[idx][8*b +: 8] <= wData[8*b +: 8];
                end
            end
        end
    end

    for (genvar i = 0; i < NumRegs; i++) begin : g_reg_out
        assign reg_out[i*DataWidth +: DataWidth] = RoMask[i] ? '0 : regs_q[i];
    end

    // ------------------------------------------------------------------
    // Protocol checks (simulation)
    // ------------------------------------------------------------------
    a_enable_after_setup: assert property (@(posedge clk) disable iff (reset)
        !(state_q == IDLE && sel && enable))
        else $error("apb_subordinate_regs: enable asserted without setup phase");

    a_stable_in_access: assert property (@(posedge clk) disable iff (reset)
        (state_q == ACCESS && sel) |-> ($stable(addr) && $stable(write)))
        else $error("apb_subordinate_regs: addr/write changed during access phase");

endmodule

// File: tb/tb_apb_subordinate_regs.sv
module tb_apb_subordinate_regs;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int PW = 4;
    localparam int NR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             sel, enable, write;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wData;
    logic [DW/8-1:0]  strb;
    logic [PW-1:0]    prot;
    logic [DW-1:0]    rData;
    logic             ready, subError;
    logic [NR*DW-1:0] hw_in, reg_out;

    logic             z_sel, z_enable, z_write;
    logic [AW-1:0]    z_addr;
    logic [DW-1:0]    z_wData;
    logic [DW/8-1:0]  z_strb;
    logic [PW-1:0]    z_prot;
    logic [DW-1:0]    z_rData;
    logic             z_ready, z_subError;
    logic [NR*DW-1:0] z_hw_in, z_reg_out;

    apb_subordinate_regs #(.WaitStates(1)) dut (
        .clk(clk), .reset(reset), .sel(sel), .enable(enable), .write(write),
        .addr(addr), .wData(wData), .strb(strb), .prot(prot), .rData(rData),
        .ready(ready), .subError(subError), .hw_in(hw_in), .reg_out(reg_out)
    );

    apb_subordinate_regs #(.WaitStates(0)) dut0 (
        .clk(clk), .reset(reset), .sel(z_sel), .enable(z_enable), .write(z_write),
        .addr(z_addr), .wData(z_wData), .strb(z_strb), .prot(z_prot), .rData(z_rData),
        .ready(z_ready), .subError(z_subError), .hw_in(z_hw_in), .reg_out(z_reg_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [NR*DW-1:0] exp_regs;
    logic [DW-1:0]    rd;
    logic             er;
    int               waits;

    task automatic check(input string tag, input logic [NR*DW-1:0] obs,
                         input logic [NR*DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Full transfer on the WaitStates=1 instance. Returns the completion-cycle
    // rData/subError and the number of ready=0 access cycles seen.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] s, input logic [3:0] p,
                        output logic [DW-1:0] rd_o, output logic er_o, output int w_o);
        @(negedge clk);
        sel = 1'b1; enable = 1'b0; write = w; addr = a; wData = d; strb = s; prot = p;
        @(negedge clk);
        enable = 1'b1;
        w_o = 0;
        #1;
        while (!ready && w_o < 8) begin
            @(negedge clk);
            #1;
            w_o++;
        end
        check("xfer_ready", ready, 1'b1);
        rd_o = rData;
        er_o = subError;
        @(negedge clk);
        sel = 1'b0; enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sel = 1'b0; enable = 1'b0; write = 1'b0;
        addr = '0; wData = '0; strb = '0; prot = '0; hw_in = '0;
        z_sel = 1'b0; z_enable = 1'b0; z_write = 1'b0;
        z_addr = '0; z_wData = '0; z_strb = '0; z_prot = '0; z_hw_in = '0;
        hw_in[7*DW +: DW] = 32'hCAFE0007;
        hw_in[6*DW +: DW] = 32'h66666666;
        exp_regs = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_suberror", subError, 1'b0);
        check("rst_rdata", rData, 32'h0);
        check("rst_reg_out", reg_out, '0);
        @(negedge clk);
        reset = 1'b0;

        // 1: full write to reg1, one wait cycle
        xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 4'h0, rd, er, waits);
        check("t1_waits", waits, 1);
        check("t1_err", er, 1'b0);
        check("t1_rdata_on_write", rd, 32'h0);
        exp_regs[1*DW +: DW] = 32'hDEADBEEF;
        check("t1_reg_out", reg_out, exp_regs);

        // 2: byte-strobe write and readback
        xfer(1'b1, 32'h4, 32'h11223344, 4'b0101, 4'h0, rd, er, waits);
        check("t2_err", er, 1'b0);
        exp_regs[1*DW +: DW] = 32'hDE22BE44;
        check("t2_reg_out", reg_out, exp_regs);
        xfer(1'b0, 32'h4, 32'h0, 4'h0, 4'h0, rd, er, waits);
        check("t2_read", rd, 32'hDE22BE44);
        check("t2_read_err", er, 1'b0);

        // strb=0 write is a legal no-op
        xfer(1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, 4'h0, rd, er, waits);
        check("t2_strb0_err", er, 1'b0);
        check("t2_strb0_reg_out", reg_out, exp_regs);

        // top lane only, highest read-write register
        xfer(1'b1, 32'h14, 32'h77AABBCC, 4'b1000, 4'h0, rd, er, waits);
        check("t2_lane3_err", er, 1'b0);
        exp_regs[5*DW +: DW] = 32'h77000000;
        check("t2_lane3_reg_out", reg_out, exp_regs);

        // 3: error responses
        xfer(1'b1, 32'h20, 32'h12345678, 4'hF, 4'h0, rd, er, waits);
        check("t3_unmapped_err", er, 1'b1);
        check("t3_unmapped_regs", reg_out, exp_regs);
        xfer(1'b0, 32'h6, 32'h0, 4'h0, 4'h0, rd, er, waits);
        check("t3_misaligned_err", er, 1'b1);
        check("t3_misaligned_rdata", rd, 32'h0);
        xfer(1'b1, 32'h18, 32'h12345678, 4'hF, 4'h0, rd, er, waits);
        check("t3_ro_write_err", er, 1'b1);
        check("t3_ro_write_regs", reg_out, exp_regs);
        xfer(1'b1, 32'h0, 32'h00000055, 4'hF, 4'h0, rd, er, waits);
        check("t3_priv_write_err", er, 1'b1);
        check("t3_priv_write_regs", reg_out, exp_regs);
        xfer(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 4'h1, rd, er, waits);
        check("t3_priv_write_ok", er, 1'b0);
        exp_regs[0*DW +: DW] = 32'hA5A5A5A5;
        check("t3_priv_write_regs_ok", reg_out, exp_regs);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'h0, rd, er, waits);
        check("t3_priv_read_err", er, 1'b1);
        check("t3_priv_read_rdata", rd, 32'h0);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'b0001, rd, er, waits);
        check("t3_priv_read_ok", er, 1'b0);
        check("t3_priv_read_ok_rdata", rd, 32'hA5A5A5A5);

        // 4: read-only registers reflect hw_in
        xfer(1'b0, 32'h1C, 32'h0, 4'h0, 4'h0, rd, er, waits);
        check("t4_ro7_rdata", rd, 32'hCAFE0007);
        check("t4_ro7_err", er, 1'b0);
        xfer(1'b0, 32'h18, 32'h0, 4'hF, 4'h0, rd, er, waits);
        check("t4_ro6_rdata", rd, 32'h66666666);
        check("t4_ro_reg_out_zero", reg_out, exp_regs);

        // 5: zero-wait build, back-to-back writes
        @(negedge clk);
        z_sel = 1'b1; z_enable = 1'b0; z_write = 1'b1; z_addr = 32'h8;
        z_wData = 32'h22222222; z_strb = 4'hF; z_prot = 4'h0;
        #1 check("t5_setup1_ready", z_ready, 1'b0);
        @(negedge clk);
        z_enable = 1'b1;
        #1 check("t5_access1_ready", z_ready, 1'b1);
        check("t5_access1_err", z_subError, 1'b0);
        @(negedge clk);
        z_enable = 1'b0; z_addr = 32'hC; z_wData = 32'h33333333;
        #1 check("t5_setup2_ready", z_ready, 1'b0);
        @(negedge clk);
        z_enable = 1'b1;
        #1 check("t5_access2_ready", z_ready, 1'b1);
        check("t5_access2_err", z_subError, 1'b0);
        @(negedge clk);
        z_sel = 1'b0; z_enable = 1'b0;
        check("t5_reg2", z_reg_out[2*DW +: DW], 32'h22222222);
        check("t5_reg3", z_reg_out[3*DW +: DW], 32'h33333333);

        // 6a: abort by dropping sel during the wait cycle
        @(negedge clk);
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h10;
        wData = 32'h12345678; strb = 4'hF; prot = 4'h0;
        @(negedge clk);
        enable = 1'b1;
        #1 check("t6_wait_ready", ready, 1'b0);
        #2;
        sel = 1'b0; enable = 1'b0;
        @(negedge clk);
        #1 check("t6_abort_ready", ready, 1'b0);
        check("t6_abort_err", subError, 1'b0);
        @(negedge clk);
        #1 check("t6_idle_ready", ready, 1'b0);
        check("t6_abort_regs", reg_out, exp_regs);

        // 6b: reset in the completing cycle of a write to reg4
        @(negedge clk);
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h10;
        wData = 32'hABCD0123; strb = 4'hF; prot = 4'h0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        #1 check("t6_pre_reset_ready", ready, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        sel = 1'b0; enable = 1'b0; write = 1'b0; addr = 32'h4;
        #1 check("t6_rst_ready", ready, 1'b0);
        check("t6_rst_err", subError, 1'b0);
        check("t6_rst_rdata", rData, 32'h0);
        check("t6_rst_reg_out", reg_out, '0);
        check("t6_rst_z_reg_out", z_reg_out, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_reg4_after_reset", reg_out[4*DW +: DW], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
